hazard_controller: RTL and testbench



---
 rtl/hazard_controller.sv | 129 ++++++++++++
 tb/tb_hazard_controller.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use, multi-cycle mul/div and branch-flush sequencing.
// Optional perf counters (stall_cycles, flush_events) enabled by defining HAZARD_PERF_CNT_EN.
module hazard_controller #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FLUSH_CYCLES   = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic                      ex_valid,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
    input  logic                      ex_mem_read,
    input  logic                      ex_branch_taken,
    input  logic                      md_start,
    input  logic                      md_done,
    input  logic                      dmem_ready,
    output logic                      stall_if,
    output logic                      stall_id,
    output logic                      stall_ex,
    output logic                      bubble_ex,
    output logic                      flush_if_id,
    output logic                      flush_id_ex,
    output logic [1:0]                state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]               stall_cycles,
    output logic [31:0]               flush_events
`endif
);
    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] LOAD_USE = 2'd1;
    localparam logic [1:0] MD_WAIT  = 2'd2;
    localparam logic [1:0] FLUSH    = 2'd3;

    logic [1:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       load_use, branch, md_go;
    logic       s_if, s_id, s_ex, bub, f_ifid, f_idex;

    assign branch   = ex_valid & ex_branch_taken;
    assign md_go    = ex_valid & md_start;
    assign load_use = ex_valid & ex_mem_read & (ex_rd_addr != '0) & id_valid &
                      ((id_rs1_addr == ex_rd_addr) | (id_rs2_addr == ex_rd_addr));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_if    = 1'b0;
        s_id    = 1'b0;
        s_ex    = 1'b0;
        bub     = 1'b0;
        f_ifid  = 1'b0;
        f_idex  = 1'b0;
        case (state_q)
            RUN: begin
                if (branch) begin
                    f_ifid  = 1'b1;
                    f_idex  = 1'b1;
                    cnt_d   = 3'(FLUSH_CYCLES);
                    state_d = FLUSH;
                end else if (md_go) begin
                    s_if = 1'b1;
                    s_id = 1'b1;
                    s_ex = 1'b1;
                    if (!md_done) state_d = MD_WAIT;
                end else if (load_use) begin
                    s_if    = 1'b1;
                    s_id    = 1'b1;
                    bub     = 1'b1;
                    state_d = LOAD_USE;
                end
            end
            LOAD_USE: begin
                if (dmem_ready) state_d = RUN;
                else begin
                    s_if = 1'b1;
                    s_id = 1'b1;
                    s_ex = 1'b1;
                end
            end
            MD_WAIT: begin
                if (md_done) state_d = RUN;
                else begin
                    s_if = 1'b1;
                    s_id = 1'b1;
                    s_ex = 1'b1;
                end
            end
            default: begin
                f_ifid = 1'b1;
                cnt_d  = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_d = RUN;
            end
        endcase
    end

    // Gate with rst_n so outputs drop the instant reset asserts, whatever the inputs do.
    assign stall_if    = rst_n & s_if;
    assign stall_id    = rst_n & s_id;
    assign stall_ex    = rst_n & s_ex;
    assign bubble_ex   = rst_n & bub;
    assign flush_if_id = rst_n & f_ifid;
    assign flush_id_ex = rst_n & f_idex;
    assign state       = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= 32'd0;
            flush_events <= 32'd0;
        end else begin
            if (stall_if) stall_cycles <= stall_cycles + 32'd1;
            if (state_q == RUN && branch) flush_events <= flush_events + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// Directed table-driven bench for hazard_controller (FLUSH_CYCLES=2), plus reset corner sequences.
module tb_hazard_controller;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       id_valid, ex_valid, ex_mem_read, ex_branch_taken, md_start, md_done, dmem_ready;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic       stall_if, stall_id, stall_ex, bubble_ex, flush_if_id, flush_id_ex;
    logic [1:0] state;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_events;
`endif
    int pass_cnt = 0, total_cnt = 0;

    hazard_controller #(.REG_ADDR_WIDTH(5), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1_addr(id_rs1_addr),
        .id_rs2_addr(id_rs2_addr), .ex_valid(ex_valid), .ex_rd_addr(ex_rd_addr),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken), .md_start(md_start),
        .md_done(md_done), .dmem_ready(dmem_ready), .stall_if(stall_if), .stall_id(stall_id),
        .stall_ex(stall_ex), .bubble_ex(bubble_ex), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex), .state(state)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
    );

    always #5 clk = ~clk;

    wire [5:0] outs = {stall_if, stall_id, stall_ex, bubble_ex, flush_if_id, flush_id_ex};

    typedef struct {
        logic       iv, ev, mr, br, ms, md, dr;
        logic [4:0] rs1, rs2, rd;
        logic [5:0] eo;   // {stall_if, stall_id, stall_ex, bubble_ex, flush_if_id, flush_id_ex}
        logic [1:0] es;
    } vec_t;

    function automatic vec_t v(input logic iv, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic ev, input logic [4:0] rd, input logic mr,
                               input logic br, input logic ms, input logic md, input logic dr,
                               input logic [5:0] eo, input logic [1:0] es);
        vec_t r;
        r.iv = iv; r.rs1 = rs1; r.rs2 = rs2; r.ev = ev; r.rd = rd; r.mr = mr;
        r.br = br; r.ms = ms; r.md = md; r.dr = dr; r.eo = eo; r.es = es;
        return r;
    endfunction

    task automatic drive(input vec_t x);
        id_valid = x.iv; id_rs1_addr = x.rs1; id_rs2_addr = x.rs2;
        ex_valid = x.ev; ex_rd_addr = x.rd; ex_mem_read = x.mr;
        ex_branch_taken = x.br; md_start = x.ms; md_done = x.md; dmem_ready = x.dr;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Drive a vector just after posedge, check at negedge, advance past the next posedge.
    task automatic step(input string name, input vec_t x);
        drive(x);
        @(negedge clk);
        chk({name, ".outs"}, 32'(outs), 32'(x.eo));
        chk({name, ".state"}, 32'(state), 32'(x.es));
        @(posedge clk); #1;
    endtask

    vec_t tbl[23];
    vec_t idle;

    initial begin
        idle   = v(0,0,0, 0,0,0, 0,0,0,0, 6'b000000, 2'd0);
        tbl[0]  = idle;
        tbl[1]  = v(1,3,5, 1,5,1, 0,0,0,0, 6'b110100, 2'd0);  // load-use on rs2
        tbl[2]  = v(1,3,5, 1,5,1, 1,1,0,0, 6'b111000, 2'd1);  // branch/md ignored in LOAD_USE
        tbl[3]  = v(1,3,5, 1,5,1, 0,0,0,0, 6'b111000, 2'd1);
        tbl[4]  = v(1,3,5, 1,5,1, 0,0,0,1, 6'b000000, 2'd1);  // data returns
        tbl[5]  = idle;
        tbl[6]  = v(1,0,0, 1,0,1, 0,0,0,0, 6'b000000, 2'd0);  // x0 never stalls
        tbl[7]  = v(0,5,5, 1,5,1, 0,0,0,0, 6'b000000, 2'd0);  // id invalid
        tbl[8]  = v(1,5,5, 0,5,1, 0,0,0,0, 6'b000000, 2'd0);  // ex invalid
        tbl[9]  = v(1,5,5, 1,5,0, 0,0,0,0, 6'b000000, 2'd0);  // not a load
        tbl[10] = v(0,0,0, 1,0,0, 0,1,1,0, 6'b111000, 2'd0);  // md start+done same cycle
        tbl[11] = idle;                                       // stayed in RUN
        tbl[12] = v(0,0,0, 1,0,0, 0,1,0,0, 6'b111000, 2'd0);
        tbl[13] = v(0,0,0, 1,0,0, 0,0,0,0, 6'b111000, 2'd2);
        tbl[14] = v(0,0,0, 1,0,0, 0,0,1,0, 6'b000000, 2'd2);
        tbl[15] = idle;
        tbl[16] = v(1,5,5, 1,5,1, 1,1,0,0, 6'b000011, 2'd0);  // branch wins
        tbl[17] = v(1,5,5, 1,5,1, 1,1,0,0, 6'b000010, 2'd3);
        tbl[18] = v(1,5,5, 1,5,1, 0,0,0,0, 6'b000010, 2'd3);
        tbl[19] = idle;
        tbl[20] = v(1,7,2, 1,7,1, 0,0,0,0, 6'b110100, 2'd0);  // load-use on rs1
        tbl[21] = v(1,7,2, 1,7,1, 0,0,0,1, 6'b000000, 2'd1);
        tbl[22] = idle;

        // Reset holds outputs low even with a taken branch presented.
        drive(v(1,5,5, 1,5,1, 1,1,0,0, 6'b0, 2'd0));
        #3;
        chk("reset.outs", 32'(outs), 32'd0);
        chk("reset.state", 32'(state), 32'd0);
        @(posedge clk); #1;
        drive(idle);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 23; i++) step($sformatf("vec%0d", i), tbl[i]);

`ifdef HAZARD_PERF_CNT_EN
        chk("perf.stall_cycles", stall_cycles, 32'd7);
        chk("perf.flush_events", flush_events, 32'd1);
`endif

        // Asynchronous reset in the middle of MD_WAIT.
        step("md.start", v(0,0,0, 1,0,0, 0,1,0,0, 6'b111000, 2'd0));
        drive(v(0,0,0, 1,0,0, 0,0,0,0, 6'b0, 2'd0));
        #2;
        chk("md.wait_state", 32'(state), 32'd2);
        chk("md.wait_outs", 32'(outs), 32'b111000);
        rst_n = 1'b0;
        #1;
        chk("mdrst.outs", 32'(outs), 32'd0);
        chk("mdrst.state", 32'(state), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        chk("mdrst.stall_cycles", stall_cycles, 32'd0);
        chk("mdrst.flush_events", flush_events, 32'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        step("post_rst.lu", v(1,9,4, 1,4,1, 0,0,0,0, 6'b110100, 2'd0));
        step("post_rst.ready", v(1,9,4, 1,4,1, 0,0,0,1, 6'b000000, 2'd1));

        // Asynchronous reset in the middle of FLUSH.
        step("fl.branch", v(0,0,0, 1,0,0, 1,0,0,0, 6'b000011, 2'd0));
        drive(idle);
        #2;
        chk("fl.mid_outs", 32'(outs), 32'b000010);
        rst_n = 1'b0;
        #1;
        chk("flrst.outs", 32'(outs), 32'd0);
        chk("flrst.state", 32'(state), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step("post_flrst.idle", idle);
        step("post_flrst.branch", v(0,0,0, 1,0,0, 1,0,0,0, 6'b000011, 2'd0));
        step("post_flrst.f1", idle.iv ? idle : v(0,0,0, 0,0,0, 0,0,0,0, 6'b000010, 2'd3));
        step("post_flrst.f2", v(0,0,0, 0,0,0, 0,0,0,0, 6'b000010, 2'd3));
        step("post_flrst.run", idle);
`ifdef HAZARD_PERF_CNT_EN
        chk("post_flrst.flush_events", flush_events, 32'd1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
